axis_frame_tx: RTL and testbench

Streaming transmitter that packs 256-bit pixel groups from the camera-side pixel source into AXI-Stream master beats addressed to an image processor instance. It is the transmitting end of the image processor's AXI-Stream slave port. It tags each beat with frame ID (`tid`) and processor address (`tdest`), asserts `tlast` on the final beat of each 320x240 frame, and decouples source stalls from sink back-pressure with a small FIFO.

---
 rtl/image_processor_pkg.sv | 25 ++
 rtl/axis_tx_fifo.sv | 49 ++++
 rtl/axis_frame_tx.sv | 154 +++++++++++++++
 tb/tb_axis_frame_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_processor_pkg.sv
// Shared image-processor definitions: frame geometry, transmitter FSM states and the
// layout of one buffered AXI-Stream beat.
package image_processor_pkg;

   localparam int unsigned FRAME_ROW_PNUM  = 240;
   localparam int unsigned FRAME_COL_PGNUM = 10;
   localparam int unsigned BEATS_PER_FRAME = FRAME_ROW_PNUM * FRAME_COL_PGNUM;

   localparam int unsigned PG_WIDTH     = 256;
   localparam int unsigned AXIS_TID_W   = 2;
   localparam int unsigned AXIS_TDEST_W = 1;

   typedef enum logic [0:0] {
      StIdle,
      StStream
   } tx_state_t;

   typedef struct packed {
      logic [AXIS_TID_W-1:0]   tid;
      logic [AXIS_TDEST_W-1:0] tdest;
      logic                    tlast;
      logic [PG_WIDTH-1:0]     data;
   } fifo_entry_t;

endpackage

// File: rtl/axis_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags; DEPTH must be a power of 2.
module axis_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             wr, rd;

   assign full_o    = (count_q == (PtrW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign wr        = wr_en_i && !full_o;
   assign rd        = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         unique case ({wr, rd})
            2'b10:   count_q <= count_q + (PtrW+1)'(1);
            2'b01:   count_q <= count_q - (PtrW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/axis_frame_tx.sv
// Packs pixel groups into tagged AXI-Stream beats, one frame per tid, through a small FIFO.
// Optional statistics outputs are enabled with AXIS_FRAME_TX_STATS_EN.
module axis_frame_tx #(
   parameter int unsigned IP_AMT          = 1,
   parameter int unsigned PG_WIDTH        = 256,
   parameter int unsigned AXIS_TID_W      = 2,
   parameter int unsigned AXIS_TDEST_W    = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
   parameter int unsigned AXIS_TDATA_W    = PG_WIDTH,
   parameter int unsigned AXIS_TKEEP_W    = AXIS_TDATA_W / 8,
   parameter int unsigned AXIS_TSTRB_W    = AXIS_TDATA_W / 8,
   parameter int unsigned FRAME_ROW_PNUM  = image_processor_pkg::FRAME_ROW_PNUM,
   parameter int unsigned FRAME_COL_PGNUM = image_processor_pkg::FRAME_COL_PGNUM,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PG_WIDTH-1:0]     pg_data_i,
   input  logic                    pg_valid_i,
   output logic                    pg_ready_o,
   input  logic [AXIS_TDEST_W-1:0] dest_i,
   output logic [AXIS_TID_W-1:0]   m_tid_o,
   output logic [AXIS_TDEST_W-1:0] m_tdest_o,
   output logic [AXIS_TDATA_W-1:0] m_tdata_o,
   output logic [AXIS_TKEEP_W-1:0] m_tkeep_o,
   output logic [AXIS_TSTRB_W-1:0] m_tstrb_o,
   output logic                    m_tlast_o,
   output logic                    m_tvalid_o,
   input  logic                    m_tready_i,
   output logic                    frame_done_o
`ifdef AXIS_FRAME_TX_STATS_EN
   ,
   output logic [15:0]             frame_cnt_o,
   output logic [31:0]             stall_cnt_o
`endif
);

   import image_processor_pkg::*;

   localparam int unsigned Beats  = FRAME_ROW_PNUM * FRAME_COL_PGNUM;
   localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned EntryW = AXIS_TID_W + AXIS_TDEST_W + 1 + AXIS_TDATA_W;

   tx_state_t               state_q, state_d;
   logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [AXIS_TID_W-1:0]   cur_tid_q, cur_tid_d;
   logic [AXIS_TDEST_W-1:0] cur_dest_q, cur_dest_d;
   logic [AXIS_TDEST_W-1:0] wr_dest;
   logic                    wr_last;
   logic                    push, pop, fifo_full, fifo_empty, frame_done_q;
   logic [EntryW-1:0]       wr_entry, rd_entry;

   assign push = pg_valid_i && !fifo_full;
   assign pop  = m_tvalid_o && m_tready_i;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      cur_tid_d  = cur_tid_q;
      cur_dest_d = cur_dest_q;
      wr_dest    = cur_dest_q;
      wr_last    = 1'b0;
      unique case (state_q)
         StIdle: begin
            // The first beat carries the fresh destination, not the stale latched one.
            wr_dest = dest_i;
            if (push) begin
               cur_dest_d = dest_i;
               if (Beats == 1) begin
                  wr_last   = 1'b1;
                  cur_tid_d = cur_tid_q + AXIS_TID_W'(1);
               end else begin
                  beat_cnt_d = CntW'(1);
                  state_d    = StStream;
               end
            end
         end
         StStream: begin
            if (push) begin
               if (beat_cnt_q == CntW'(Beats - 1)) begin
                  wr_last    = 1'b1;
                  beat_cnt_d = '0;
                  cur_tid_d  = cur_tid_q + AXIS_TID_W'(1);
                  state_d    = StIdle;
               end else begin
                  beat_cnt_d = beat_cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         beat_cnt_q   <= '0;
         cur_tid_q    <= '0;
         cur_dest_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         cur_tid_q    <= cur_tid_d;
         cur_dest_q   <= cur_dest_d;
         frame_done_q <= pop && m_tlast_o;
      end
   end

   assign wr_entry = {cur_tid_q, wr_dest, wr_last, AXIS_TDATA_W'(pg_data_i)};

   axis_tx_fifo #(
      .WIDTH (EntryW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push),
      .wr_data_i (wr_entry),
      .rd_en_i   (pop),
      .rd_data_o (rd_entry),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign {m_tid_o, m_tdest_o, m_tlast_o, m_tdata_o} = rd_entry;
   assign m_tkeep_o    = '1;
   assign m_tstrb_o    = '1;
   assign m_tvalid_o   = !fifo_empty;
   assign pg_ready_o   = !fifo_full;
   assign frame_done_o = frame_done_q;

`ifdef AXIS_FRAME_TX_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (frame_done_q) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (m_tvalid_o && !m_tready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign frame_cnt_o = frame_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx: table of frame vectors checked against a beat scoreboard.
`timescale 1ns/1ps
module tb_axis_frame_tx;

   localparam int Beats = 2400;
   localparam int Depth = 4;

   typedef struct {
      logic [1:0]   tid;
      logic [0:0]   dest;
      logic         last;
      logic [255:0] data;
   } beat_t;

   typedef struct {
      logic [0:0] dest;
      int         vpct;
      int         rpct;
      bit         toggle;
      int         stall_at;
      int         stall_len;
      int         npush;
      bit         abort;
      logic [1:0] exp_tid;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] pg_data_i = '0;
   logic         pg_valid_i = 1'b0;
   logic         pg_ready_o;
   logic [0:0]   dest_i = '0;
   logic [1:0]   m_tid_o;
   logic [0:0]   m_tdest_o;
   logic [255:0] m_tdata_o;
   logic [31:0]  m_tkeep_o, m_tstrb_o;
   logic         m_tlast_o, m_tvalid_o;
   logic         m_tready_i = 1'b0;
   logic         frame_done_o;
`ifdef AXIS_FRAME_TX_STATS_EN
   logic [15:0]  frame_cnt_o;
   logic [31:0]  stall_cnt_o;
`endif

   always #5 clk = ~clk;

   axis_frame_tx dut (
      .clk          (clk),
      .rst          (rst),
      .pg_data_i    (pg_data_i),
      .pg_valid_i   (pg_valid_i),
      .pg_ready_o   (pg_ready_o),
      .dest_i       (dest_i),
      .m_tid_o      (m_tid_o),
      .m_tdest_o    (m_tdest_o),
      .m_tdata_o    (m_tdata_o),
      .m_tkeep_o    (m_tkeep_o),
      .m_tstrb_o    (m_tstrb_o),
      .m_tlast_o    (m_tlast_o),
      .m_tvalid_o   (m_tvalid_o),
      .m_tready_i   (m_tready_i),
      .frame_done_o (frame_done_o)
`ifdef AXIS_FRAME_TX_STATS_EN
      ,
      .frame_cnt_o  (frame_cnt_o),
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   int         errors = 0;
   int         checks = 0;
   beat_t      q[$];
   bit         m_stream;
   int         m_beat;
   logic [1:0] m_tid;
   logic [0:0] m_dest;
   logic       fd_exp;
   bit         hold;
   beat_t      prev;
   int         exp_stall, exp_frames;
   int         obs_len, n_obs, fd_seen;
   logic [1:0] obs_tid [16];
   logic [0:0] obs_dest [16];
   int         obs_n [16];
   vec_t       vecs [9];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check outputs against the model, drive inputs, advance the model.
   task automatic step(input logic v, input logic r, input logic [0:0] d, output logic pushed);
      logic [255:0] data;
      logic         pop_m;
      beat_t        e;
      int           b;
      chk("m_tvalid", m_tvalid_o, q.size() != 0);
      chk("pg_ready", pg_ready_o, q.size() < Depth);
      chk("frame_done", frame_done_o, fd_exp);
      if (frame_done_o) fd_seen++;
      if (m_tvalid_o && q.size() != 0) begin
         chk("head_tid", m_tid_o, q[0].tid);
         chk("head_tdest", m_tdest_o, q[0].dest);
         chk("head_tlast", m_tlast_o, q[0].last);
         chk("head_tdata", m_tdata_o, q[0].data);
      end
      if (hold) begin
         chk("stable_tvalid", m_tvalid_o, 1'b1);
         chk("stable_tid", m_tid_o, prev.tid);
         chk("stable_tdest", m_tdest_o, prev.dest);
         chk("stable_tlast", m_tlast_o, prev.last);
         chk("stable_tdata", m_tdata_o, prev.data);
      end
      for (int k = 0; k < 8; k++) data[k*32 +: 32] = $urandom;
      pg_data_i  = data;
      pg_valid_i = v;
      dest_i     = d;
      m_tready_i = r;
      pushed = v && (q.size() < Depth);
      pop_m  = (q.size() != 0) && r;
      hold   = m_tvalid_o && !r;
      prev   = '{tid: m_tid_o, dest: m_tdest_o, last: m_tlast_o, data: m_tdata_o};
      if (hold) exp_stall++;
      if (m_tvalid_o && r) begin
         obs_len++;
         if (obs_len == 1 && n_obs < 16) begin
            obs_tid[n_obs]  = m_tid_o;
            obs_dest[n_obs] = m_tdest_o;
         end
         if (m_tlast_o) begin
            if (n_obs < 16) obs_n[n_obs] = obs_len;
            n_obs++;
            obs_len = 0;
         end
      end
      fd_exp = 1'b0;
      if (pop_m) begin
         fd_exp = q[0].last;
         void'(q.pop_front());
      end
      if (fd_exp) exp_frames++;
      if (pushed) begin
         b = m_stream ? m_beat + 1 : 1;
         if (!m_stream) m_dest = d;
         e = '{tid: m_tid, dest: m_dest, last: (b == Beats), data: data};
         if (e.last) begin
            m_tid    = m_tid + 2'd1;
            m_stream = 1'b0;
            m_beat   = 0;
         end else begin
            m_stream = 1'b1;
            m_beat   = b;
         end
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      pg_valid_i = 1'b0;
      m_tready_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_tvalid", m_tvalid_o, 1'b0);
      chk("rst_frame_done", frame_done_o, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_stream   = 1'b0;
      m_beat     = 0;
      m_tid      = '0;
      m_dest     = '0;
      fd_exp     = 1'b0;
      hold       = 1'b0;
      exp_stall  = 0;
      exp_frames = 0;
      obs_len    = 0;
      @(posedge clk);
      #1;
      chk("rst_tlast", m_tlast_o, 1'b0);
      chk("rst_tid", m_tid_o, 2'd0);
      chk("rst_tdest", m_tdest_o, 1'b0);
      chk("rst_tdata", m_tdata_o, 256'd0);
      chk("rst_tkeep", m_tkeep_o, 32'hffff_ffff);
      chk("rst_tstrb", m_tstrb_o, 32'hffff_ffff);
      chk("rst_pg_ready", pg_ready_o, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      int         pushed_n = 0;
      int         cyc = 0;
      int         stall_left = 0;
      int         occ0 = 0;
      int         win = 0;
      int         exp_win;
      bit         in_win = 1'b0;
      bit         done_win = 1'b0;
      logic       p, vv, rr;
      logic [0:0] dd;
      while (pushed_n < v.npush) begin
         if (cyc >= 40000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: pushed %0d required %0d", pushed_n, v.npush);
            break;
         end
         vv = ($urandom_range(99) < v.vpct);
         rr = ($urandom_range(99) < v.rpct);
         if (v.stall_at >= 0 && !in_win && !done_win && pushed_n == v.stall_at) begin
            in_win     = 1'b1;
            stall_left = v.stall_len;
            occ0       = q.size();
            win        = 0;
         end
         if (in_win) rr = 1'b0;
         dd = (!v.toggle || pushed_n == 0) ? v.dest : 1'($urandom);
         step(vv, rr, dd, p);
         if (p) pushed_n++;
         if (in_win) begin
            if (p) win++;
            stall_left--;
            if (stall_left == 0) begin
               in_win   = 1'b0;
               done_win = 1'b1;
               exp_win  = (v.stall_len < Depth - occ0) ? v.stall_len : Depth - occ0;
               chk("stall_pushes", win, exp_win);
            end
         end
         cyc++;
      end
   endtask

   task automatic drain();
      logic p;
      int   extra = 0;
      for (int i = 0; i < 60 && extra < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, p);
         if (q.size() == 0) extra++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   idx;
      vec_t sv;
      vecs[0] = '{dest: 1'b1, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd0};
      vecs[1] = '{dest: 1'b0, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd1};
      vecs[2] = '{dest: 1'b1, vpct: 100, rpct: 100, toggle: 0, stall_at: 500, stall_len: 10,
                  npush: Beats, abort: 0, exp_tid: 2'd2};
      vecs[3] = '{dest: 1'b0, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd3};
      vecs[4] = '{dest: 1'b1, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd0};
      vecs[5] = '{dest: 1'b0, vpct: 50, rpct: 50, toggle: 1, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd1};
      vecs[6] = '{dest: 1'b1, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: 1000, abort: 1, exp_tid: 2'd2};
      vecs[7] = '{dest: 1'b0, vpct: 100, rpct: 100, toggle: 0, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd0};
      vecs[8] = '{dest: 1'b1, vpct: 70, rpct: 80, toggle: 1, stall_at: -1, stall_len: 0,
                  npush: Beats, abort: 0, exp_tid: 2'd1};
      n_obs   = 0;
      fd_seen = 0;
      do_reset();

      foreach (vecs[i]) begin
         run_vec(vecs[i]);
         if (vecs[i].abort) do_reset();
      end
      drain();

      idx = 0;
      foreach (vecs[i]) begin
         if (!vecs[i].abort && idx < 16) begin
            chk("frame_tid", obs_tid[idx], vecs[i].exp_tid);
            chk("frame_tdest", obs_dest[idx], vecs[i].dest);
            chk("frame_len", obs_n[idx], Beats);
            idx++;
         end
      end
      chk("frame_total", n_obs, idx);
      chk("frame_done_total", fd_seen, idx);

      // Two frames with a seven-cycle sink stall in the first one.
      do_reset();
      sv = '{dest: 1'b1, vpct: 100, rpct: 100, toggle: 0, stall_at: 300, stall_len: 7,
             npush: Beats, abort: 0, exp_tid: 2'd0};
      run_vec(sv);
      sv.stall_at = -1;
      sv.exp_tid  = 2'd1;
      run_vec(sv);
      drain();
      chk("stats_frames_seen", n_obs, idx + 2);
`ifdef AXIS_FRAME_TX_STATS_EN
      chk("frame_cnt", frame_cnt_o, 16'd2);
      chk("frame_cnt_model", frame_cnt_o, exp_frames);
      chk("stall_cnt", stall_cnt_o, 32'd7);
      chk("stall_cnt_model", stall_cnt_o, exp_stall);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
